// File: rtl/simon_player_input.sv
`default_nettype none
// =============================================================================
// simon_player_input : synchronise, debounce and encode the four Simon buttons
//                      into the playerNum / playerPressed handshake.
// Optional feature macro: PLAYER_TIMEOUT_EN (player-turn idle timeout flag).
// Revision: 1.0
// =============================================================================
module simon_player_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic       multiPress,
    output logic [7:0] pressCount,
    output logic       playerTimeout
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        WAIT_REL = 2'd1,
        IDLE     = 2'd2,
        PRESSED  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] sync_meta;
    logic [3:0] sync;
    logic [3:0] sync_prev;
    logic [3:0] stable_cnt;
    logic [3:0] stable_now;
    logic [3:0] deb;
    logic [1:0] deb_idx;
    logic       single;
    logic       lock;
    logic [1:0] num_next;
    logic       pressed_next;
    logic       multi_next;
    logic       multi_hold;
    logic       multi_hold_next;
    logic [7:0] count_next;

    assign lock   = simonTurn | gameOver;
    assign single = $onehot(deb);

    // stable_now counts how many consecutive cycles sync has held its value
    always_comb begin
        if (sync != sync_prev) begin
            stable_now = 4'd1;
        end else if (stable_cnt == 4'hF) begin
            stable_now = 4'hF;
        end else begin
            stable_now = stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta  <= 4'b0;
            sync       <= 4'b0;
            sync_prev  <= 4'b0;
            stable_cnt <= 4'b0;
            deb        <= 4'b0;
        end else begin
            sync_meta  <= btn;
            sync       <= sync_meta;
            sync_prev  <= sync;
            stable_cnt <= stable_now;
            if (stable_now >= DEB_TARGET) begin
                deb <= sync;
            end
        end
    end

    always_comb begin
        case (deb)
            4'b0010: deb_idx = 2'd1;
            4'b0100: deb_idx = 2'd2;
            4'b1000: deb_idx = 2'd3;
            default: deb_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= LOCKED;
            playerNum     <= 2'd0;
            playerPressed <= 1'b0;
            multiPress    <= 1'b0;
            multi_hold    <= 1'b0;
            pressCount    <= 8'd0;
        end else begin
            state         <= state_next;
            playerNum     <= num_next;
            playerPressed <= pressed_next;
            multiPress    <= multi_next;
            multi_hold    <= multi_hold_next;
            pressCount    <= count_next;
        end
    end

    always_comb begin
        state_next      = state;
        num_next        = playerNum;
        pressed_next    = playerPressed;
        multi_next      = 1'b0;
        multi_hold_next = 1'b0;
        count_next      = pressCount;
        if (lock) begin
            state_next   = LOCKED;
            pressed_next = 1'b0;
            if (state != LOCKED) begin
                count_next = 8'd0;
            end
        end else begin
            case (state)
                LOCKED: begin
                    state_next = WAIT_REL;
                end
                WAIT_REL: begin
                    if (deb == 4'b0) begin
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    if (single) begin
                        num_next     = deb_idx;
                        pressed_next = 1'b1;
                        state_next   = PRESSED;
                        if (pressCount != 8'hFF) begin
                            count_next = pressCount + 8'd1;
                        end
                    end else if (deb != 4'b0) begin
                        // one pulse per multi-button episode, not per cycle
                        multi_next      = ~multi_hold;
                        multi_hold_next = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!deb[playerNum]) begin
                        pressed_next = 1'b0;
                        state_next   = WAIT_REL;
                    end
                end
                default: begin
                    state_next = LOCKED;
                end
            endcase
        end
    end

`ifdef PLAYER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_TARGET = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_cnt;
    logic        timeout_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt     <= 16'd0;
            timeout_flag <= 1'b0;
        end else if (lock) begin
            idle_cnt     <= 16'd0;
            timeout_flag <= 1'b0;
        end else if ((state_next != state) &&
                     ((state_next == WAIT_REL) || (state_next == PRESSED))) begin
            idle_cnt <= 16'd0;
        end else if (((state == WAIT_REL) || (state == IDLE)) &&
                     (idle_cnt != TIMEOUT_TARGET)) begin
            idle_cnt <= idle_cnt + 16'd1;
            if (idle_cnt + 16'd1 == TIMEOUT_TARGET) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign playerTimeout = timeout_flag;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign playerTimeout      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simon_player_input.sv
`default_nettype none
// =============================================================================
// tb_simon_player_input : randomized and directed bench for simon_player_input
//                         against a behavioural model of the button rules.
// Revision: 1.0
// =============================================================================
module tb_simon_player_input;

    localparam int DEB = 3;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       simonTurn = 1'b1;
    logic       gameOver = 1'b0;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic       multiPress;
    logic [7:0] pressCount;
    logic       playerTimeout;

    int n_cmp = 0;
    int n_bad = 0;

    simon_player_input #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .btn(btn), .simonTurn(simonTurn), .gameOver(gameOver),
        .playerNum(playerNum), .playerPressed(playerPressed), .multiPress(multiPress),
        .pressCount(pressCount), .playerTimeout(playerTimeout)
    );

    always #5 clk = ~clk;

    // Reference model: raw-sample history, windowed debounce, press bookkeeping
    logic [3:0] hist [0:15];
    logic [3:0] deb_m = 4'b0;
    bit         m_locked = 1'b1;
    bit         m_armed = 1'b0;
    int         m_held = -1;
    logic [1:0] m_num = 2'd0;
    logic       m_pressed = 1'b0;
    logic       m_multi = 1'b0;
    bit         m_mseen = 1'b0;
    int         m_count = 0;
    int         m_idle = 0;
    logic       m_to = 1'b0;

    function automatic logic exp_timeout();
`ifdef PLAYER_TIMEOUT_EN
        return m_to;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) hist[i] = 4'b0;
            deb_m = 4'b0; m_locked = 1'b1; m_armed = 1'b0; m_held = -1;
            m_num = 2'd0; m_pressed = 1'b0; m_multi = 1'b0; m_mseen = 1'b0;
            m_count = 0; m_idle = 0; m_to = 1'b0;
        end else begin
            int  pc;
            bit  tick;
            bit  seen;
            bit  same;
            pc   = $countones(deb_m);
            tick = 1'b0;
            seen = 1'b0;
            m_multi = 1'b0;
            if (simonTurn || gameOver) begin
                if (!m_locked) m_count = 0;
                m_locked = 1'b1; m_armed = 1'b0; m_held = -1; m_pressed = 1'b0;
                m_idle = 0; m_to = 1'b0;
            end else if (m_locked) begin
                m_locked = 1'b0; m_armed = 1'b0; m_idle = 0;
            end else if (m_held >= 0) begin
                if (!deb_m[m_held]) begin
                    m_held = -1; m_pressed = 1'b0; m_armed = 1'b0; m_idle = 0;
                end
            end else if (!m_armed) begin
                if (deb_m == 4'b0) m_armed = 1'b1;
                tick = 1'b1;
            end else if (pc == 1) begin
                for (int i = 0; i < 4; i++) if (deb_m[i]) m_held = i;
                m_num = 2'(m_held); m_pressed = 1'b1; m_idle = 0;
                if (m_count < 255) m_count = m_count + 1;
            end else begin
                if (pc > 1 && !m_mseen) m_multi = 1'b1;
                seen = (pc > 1);
                tick = 1'b1;
            end
            m_mseen = seen;
            if (tick && m_idle < TMO) begin
                m_idle = m_idle + 1;
                if (m_idle == TMO) m_to = 1'b1;
            end
            // debounced value = oldest synced sample once DEB consecutive samples agree
            same = 1'b1;
            for (int i = 2; i <= DEB; i++) if (hist[i] != hist[1]) same = 1'b0;
            if (same) deb_m = hist[1];
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = btn;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; simonTurn = 1'b1; btn = 4'b0001;
        tick_n(3);
        n_cmp++;
        if ({playerNum, playerPressed, multiPress, pressCount, playerTimeout} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {playerNum, playerPressed, multiPress, pressCount, playerTimeout});
        end
        reset = 1'b1;
        tick_n(10);
        n_cmp++;
        if ({playerPressed, pressCount} !== 9'd0) begin
            n_bad++;
            $display("FAIL locked_after_reset: got %h expected 0", {playerPressed, pressCount});
        end
    endtask

    task automatic test_carryover();
        int bad;
        simonTurn = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (playerPressed !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL carryover_blocked: got %0d pressed cycles expected 0", bad);
        end
        btn = 4'b0000;
        tick_n(10);
        btn = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                n_cmp++;
                if (playerPressed !== 1'b0) begin
                    n_bad++;
                    $display("FAIL latency_early: got %b expected 0 at edge 5", playerPressed);
                end
            end
        end
        n_cmp++;
        if ({playerPressed, playerNum, pressCount} !== {1'b1, 2'd0, 8'd1}) begin
            n_bad++;
            $display("FAIL latency_press: got %h expected %h",
                     {playerPressed, playerNum, pressCount}, {1'b1, 2'd0, 8'd1});
        end
        btn = 4'b0000;
        tick_n(10);
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        repeat (8) begin
            btn = 4'b0100; tick_n(2);
            btn = 4'b0000; tick_n(1);
            if (playerPressed !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL glitch_reject: got %0d pressed samples expected 0", bad);
        end
        btn = 4'b0100; tick_n(8);
        n_cmp++;
        if ({playerPressed, playerNum} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL steady_press: got %b expected 110", {playerPressed, playerNum});
        end
        btn = 4'b0101; tick_n(8);
        n_cmp++;
        if ({playerPressed, playerNum} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL frozen_num: got %b expected 110", {playerPressed, playerNum});
        end
        btn = 4'b0001; tick_n(7);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (playerPressed !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL release_gap: got %0d pressed cycles expected 0", bad);
        end
        btn = 4'b0000; tick_n(10);
    endtask

    task automatic test_multi();
        int pulses;
        int pressed_seen;
        pulses = 0; pressed_seen = 0;
        btn = 4'b1001;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (multiPress === 1'b1) pulses++;
            if (playerPressed !== 1'b0) pressed_seen++;
        end
        n_cmp++;
        if (pulses != 1 || pressed_seen != 0) begin
            n_bad++;
            $display("FAIL multi_pulse: got %0d pulses/%0d pressed expected 1/0", pulses, pressed_seen);
        end
        btn = 4'b1000; tick_n(8);
        n_cmp++;
        if ({playerPressed, playerNum} !== {1'b1, 2'd3}) begin
            n_bad++;
            $display("FAIL multi_resolve: got %b expected 111", {playerPressed, playerNum});
        end
        btn = 4'b0000; tick_n(10);
    endtask

    task automatic test_lock_pressed();
        int bad;
        btn = 4'b0010; tick_n(8);
        n_cmp++;
        if ({playerPressed, playerNum} !== {1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL lock_setup: got %b expected 101", {playerPressed, playerNum});
        end
        gameOver = 1'b1; tick_n(1);
        n_cmp++;
        if ({playerPressed, playerNum, pressCount} !== {1'b0, 2'd1, 8'd0}) begin
            n_bad++;
            $display("FAIL lock_drop: got %h expected %h",
                     {playerPressed, playerNum, pressCount}, {1'b0, 2'd1, 8'd0});
        end
        gameOver = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (playerPressed !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL unlock_held: got %0d pressed cycles expected 0", bad);
        end
        btn = 4'b0000; tick_n(10);
        btn = 4'b0010; tick_n(8);
        n_cmp++;
        if ({playerPressed, pressCount} !== {1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL repress_after_lock: got %h expected %h", {playerPressed, pressCount}, {1'b1, 8'd1});
        end
        btn = 4'b0000; tick_n(10);
    endtask

    task automatic test_saturate();
        repeat (260) begin
            btn = 4'b0001; tick_n(7);
            btn = 4'b0000; tick_n(8);
        end
        n_cmp++;
        if (pressCount !== 8'd255) begin
            n_bad++;
            $display("FAIL saturate: got %0d expected 255", pressCount);
        end
        simonTurn = 1'b1; tick_n(1);
        n_cmp++;
        if (pressCount !== 8'd0) begin
            n_bad++;
            $display("FAIL lock_clears_count: got %0d expected 0", pressCount);
        end
        simonTurn = 1'b0; tick_n(3);
    endtask

    task automatic test_async_reset();
        btn = 4'b0100; tick_n(8);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({playerNum, playerPressed, multiPress, pressCount, playerTimeout} !== 13'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected 0",
                     {playerNum, playerPressed, multiPress, pressCount, playerTimeout});
        end
        @(negedge clk);
        simonTurn = 1'b1; reset = 1'b1;
        tick_n(4);
        simonTurn = 1'b0;
        tick_n(12);
        n_cmp++;
        if (playerPressed !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_held: got %b expected 0", playerPressed);
        end
        btn = 4'b0000; tick_n(10);
    endtask

    task automatic test_timeout();
        int bad;
        simonTurn = 1'b1; tick_n(2);
        simonTurn = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (playerTimeout !== exp_timeout()) bad++;
        end
        n_cmp++;
`ifdef PLAYER_TIMEOUT_EN
        if (bad != 0 || playerTimeout !== 1'b1) begin
`else
        if (bad != 0 || playerTimeout !== 1'b0) begin
`endif
            n_bad++;
            $display("FAIL timeout_flag: got %b with %0d model disagreements", playerTimeout, bad);
        end
        simonTurn = 1'b1; tick_n(1);
        n_cmp++;
        if (playerTimeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b expected 0", playerTimeout);
        end
        simonTurn = 1'b0; tick_n(3);
    endtask

    task automatic test_random();
        int cycles;
        int bad;
        int len;
        int kind;
        logic [12:0] act;
        logic [12:0] exp;
        cycles = 0; bad = 0;
        while (cycles < 2500) begin
            len  = $urandom_range(1, 10);
            kind = $urandom_range(0, 9);
            if (kind < 3)      btn = 4'b0000;
            else if (kind < 8) btn = 4'(1 << $urandom_range(0, 3));
            else               btn = 4'($urandom);
            simonTurn = ($urandom_range(0, 14) == 0);
            gameOver  = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                cycles++;
                act = {playerNum, playerPressed, multiPress, pressCount, playerTimeout};
                exp = {m_num, m_pressed, m_multi, 8'(m_count), exp_timeout()};
                n_cmp++;
                if (act !== exp) begin
                    n_bad++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random_cycle %0d: got %h expected %h", cycles, act, exp);
                end
            end
        end
        simonTurn = 1'b0; gameOver = 1'b0; btn = 4'b0000;
        tick_n(12);
    endtask

    initial begin
        test_reset();
        test_carryover();
        test_glitch();
        test_multi();
        test_lock_pressed();
        test_saturate();
        test_async_reset();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_player_input.md
Name: simon_player_input

Overview:
- Player-side front end for the Simon game controller.
- Turns four raw push-buttons into the playerNum / playerPressed handshake that the controller consumes during the user turn.
- Synchronises and debounces the buttons, encodes a single press to a 2-bit index, and holds it stable for the whole press.
- Locks out input while simonTurn or gameOver is high.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive identical synchronised samples needed before the debounced vector updates (range 1..15).
- TIMEOUT_CYCLES, 300: idle player-turn cycles before playerTimeout asserts (5 s at 60 Hz). Used only with PLAYER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, 60 Hz.
- reset  input  1  asynchronous, active-low reset.
- btn  input  4  raw buttons, active-high, asynchronous to clk. Bit i means colour i.
- simonTurn  input  1  high while the controller is playing its sequence.
- gameOver  input  1  high once the game has ended.
- playerNum  output  2  index of the accepted button; stable while playerPressed is high.
- playerPressed  output  1  high while the accepted button is held (debounced).
- multiPress  output  1  one-cycle pulse when more than one debounced button is seen in IDLE.
- pressCount  output  8  accepted presses since the last lock; saturates at 255.
- playerTimeout  output  1  player-turn timeout flag (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, debounced vector, stability counter and pressCount all clear to 0.
  - State = LOCKED.
  - playerNum=0, playerPressed=0, multiPress=0, playerTimeout=0.
- Synchroniser: 2-flop per bit, giving sync[3:0].
- Debounce:
  - A shared stability counter resets whenever sync differs from its previous-cycle value.
  - When sync has been unchanged for DEBOUNCE_CYCLES cycles, deb <= sync.
  - Counter is 4 bits and saturates.
- Latency: a raw change held steady produces the playerPressed change exactly DEBOUNCE_CYCLES+3 clocks later (default 6).
- Lock condition: lock = simonTurn | gameOver.
  - Lock is checked in every state and has priority over all other transitions.
  - When lock is high, the next state is LOCKED, playerPressed drops on the next edge, and playerNum holds its value.
- FSM states:
  - LOCKED: outputs idle. When lock=0, go to WAIT_REL. Entering LOCKED from any other state clears pressCount.
  - WAIT_REL: stay until deb==0, then go to IDLE. This blocks a press carried over from before the unlock or a press of another button, and guarantees playerPressed is low for at least 1 cycle between presses.
  - IDLE, exactly one deb bit set: playerNum <= its index, playerPressed <= 1, pressCount++ (saturating), go to PRESSED.
  - IDLE, two or more deb bits set: pulse multiPress for 1 cycle, stay in IDLE, no press accepted. Releasing to a single bit then accepts that bit.
  - PRESSED: playerPressed=1 and playerNum is frozen. Other buttons are ignored. When deb[playerNum] clears, playerPressed <= 0 and go to WAIT_REL.
- Simultaneous events:
  - Lock asserting in the same cycle as a release: lock wins, go to LOCKED, pressCount clears.
  - Lock asserting in the same cycle an IDLE press qualifies: the press is not accepted and pressCount is not incremented.
- Reset mid-press: all outputs drop asynchronously. After reset deasserts, the block stays in LOCKED until lock=0, then waits in WAIT_REL for all buttons released.
- multiPress is never asserted outside IDLE.

Optional Feature:
- Macro: PLAYER_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter clears on entry to WAIT_REL or PRESSED, and also when lock=1.
  - It increments in WAIT_REL and IDLE.
  - When it reaches TIMEOUT_CYCLES, playerTimeout <= 1 and stays high until the next entry to LOCKED or reset.
  - The counter stops at TIMEOUT_CYCLES.
  - While playerTimeout=1, presses are still accepted.
- Undefined: playerTimeout is tied to 0, and no counter logic exists.

Test Plan:
- Reset release with simonTurn=1, btn=0001 held -> all outputs 0 and state LOCKED. Drop simonTurn while btn=0001 is still held -> no press accepted until btn is released. Press again -> playerPressed rises 6 clocks after the raw edge, playerNum=0, pressCount=1.
- In IDLE, btn=0100 with 1-cycle glitches every 2 cycles -> playerPressed stays 0. Hold it steady -> playerPressed=1, playerNum=2. While held, also press btn[0] -> playerNum stays 2. Release bit 2 -> playerPressed low for at least 1 cycle.
- In IDLE, raw btn=1001 applied in the same cycle -> exactly one multiPress pulse, playerPressed=0. Release bit 0 -> the press is accepted with playerNum=3.
- In PRESSED with playerNum=1, assert gameOver -> playerPressed=0 on the next edge and pressCount=0. Deassert gameOver while the button is still held -> playerPressed stays 0 until the button is released.
- Accept 260 presses without locking -> pressCount saturates at 255. Raise simonTurn -> pressCount=0.
- PLAYER_TIMEOUT_EN, TIMEOUT_CYCLES=20, no presses after unlock -> playerTimeout=1 at idle cycle 20. Raise simonTurn -> playerTimeout=0. Build without the macro -> playerTimeout is constant 0.
